// File: rtl/tim_ctrl.sv
// Bus-mapped controller for one tim core: holds shadow/active PSC/ARR/CCR/MODE,
// sequences the core through its reset, and flags update/compare events.
module tim_ctrl #(
  parameter int CNT_W = 16,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [2:0]       bus_addr,
  input  logic [BUS_W-1:0] bus_wdata,
  output logic [BUS_W-1:0] bus_rdata,
  output logic             bus_ack,
  output logic             tim_rst,
  output logic [CNT_W-1:0] tim_prescaler,
  output logic [1:0]       tim_mode,
  output logic [CNT_W-1:0] tim_period,
  output logic [CNT_W-1:0] tim_pulse,
  input  logic [CNT_W-1:0] tim_counter,
  output logic             irq
);

  typedef enum logic [1:0] {STOP, LOAD, RUN} state_t;
  state_t state_q, state_d;

  logic             en_q, en_d, opm_q, opm_d, arpe_q, arpe_d;
  logic [1:0]       mode_q, mode_d, amode_q, amode_d;
  logic [1:0]       sr_q, sr_d, ier_q, ier_d;
  logic [CNT_W-1:0] psc_q, psc_d, arr_q, arr_d, ccr_q, ccr_d;
  logic [CNT_W-1:0] apsc_q, apsc_d, aarr_q, aarr_d, accr_q, accr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;

  logic wr, ug, moved, uev, cce, xfer;
  logic unused_wdata;

  assign unused_wdata = ^bus_wdata[BUS_W-1:CNT_W];

  assign wr    = bus_sel && bus_we;
  assign ug    = wr && (bus_addr == 3'd0) && bus_wdata[5];
  assign moved = (state_q == RUN) && (cnt_q != tim_counter);
  // Down mode reloads at ARR; up and up-down wrap through zero.
  assign uev   = moved && (tim_counter == ((amode_q == 2'b01) ? aarr_q : '0));
  assign cce   = moved && (tim_counter == accr_q);
  assign xfer  = (state_q == LOAD) || uev || ((state_q == STOP) && ug);

  always_comb begin
    en_d    = en_q;
    opm_d   = opm_q;
    arpe_d  = arpe_q;
    mode_d  = mode_q;
    amode_d = amode_q;
    sr_d    = sr_q;
    ier_d   = ier_q;
    psc_d   = psc_q;
    arr_d   = arr_q;
    ccr_d   = ccr_q;
    apsc_d  = apsc_q;
    aarr_d  = aarr_q;
    accr_d  = accr_q;
    cnt_d   = (state_q == LOAD) ? '0 : tim_counter;
    ack_d   = bus_sel;
    rdata_d = '0;

    if (bus_sel && !bus_we) begin
      case (bus_addr)
        3'd0:    rdata_d[4:0] = {mode_q, arpe_q, opm_q, en_q};
        3'd1:    rdata_d[CNT_W-1:0] = psc_q;
        3'd2:    rdata_d[CNT_W-1:0] = arr_q;
        3'd3:    rdata_d[CNT_W-1:0] = ccr_q;
        3'd4:    rdata_d[CNT_W-1:0] = tim_counter;
        3'd5:    rdata_d[1:0] = sr_q;
        3'd6:    rdata_d[1:0] = ier_q;
        default: rdata_d = '0;
      endcase
    end

    if (wr) begin
      case (bus_addr)
        3'd0: {mode_d, arpe_d, opm_d, en_d} = bus_wdata[4:0];
        3'd1: psc_d = bus_wdata[CNT_W-1:0];
        3'd2: begin
          arr_d = bus_wdata[CNT_W-1:0];
          if (!arpe_q) aarr_d = bus_wdata[CNT_W-1:0];
        end
        3'd3: begin
          ccr_d = bus_wdata[CNT_W-1:0];
          if (!arpe_q) accr_d = bus_wdata[CNT_W-1:0];
        end
        3'd5:    sr_d = sr_q & ~bus_wdata[1:0];
        3'd6:    ier_d = bus_wdata[1:0];
        default: ;
      endcase
    end

    // Hardware flag sets are applied after the W1C so they win a collision.
    if (uev) begin
      sr_d[0] = 1'b1;
      if (opm_q) en_d = 1'b0;
    end
    if (cce) sr_d[1] = 1'b1;

    if (xfer) begin
      apsc_d  = psc_d;
      aarr_d  = arr_d;
      accr_d  = ccr_d;
      amode_d = mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (en_q) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN: begin
        if (!en_d)   state_d = STOP;
        else if (ug) state_d = LOAD;
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      opm_q   <= 1'b0;
      arpe_q  <= 1'b0;
      mode_q  <= '0;
      amode_q <= '0;
      sr_q    <= '0;
      ier_q   <= '0;
      psc_q   <= '0;
      arr_q   <= '0;
      ccr_q   <= '0;
      apsc_q  <= '0;
      aarr_q  <= '0;
      accr_q  <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      en_q    <= en_d;
      opm_q   <= opm_d;
      arpe_q  <= arpe_d;
      mode_q  <= mode_d;
      amode_q <= amode_d;
      sr_q    <= sr_d;
      ier_q   <= ier_d;
      psc_q   <= psc_d;
      arr_q   <= arr_d;
      ccr_q   <= ccr_d;
      apsc_q  <= apsc_d;
      aarr_q  <= aarr_d;
      accr_q  <= accr_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_ack       = ack_q;
  assign bus_rdata     = rdata_q;
  assign tim_rst       = (state_q != RUN);
  assign tim_prescaler = apsc_q;
  assign tim_mode      = amode_q;
  assign tim_period    = aarr_q;
  assign tim_pulse     = accr_q;
  assign irq           = |(sr_q & ier_q);

endmodule

// File: tb/tb_tim_ctrl.sv
// Bench for tim_ctrl: a behavioural tim core drives tim_counter, and a register-level
// reference model predicts every output each cycle under directed and random bus traffic.
module tb_tim_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic        bus_ack, tim_rst, irq;
  logic [15:0] tim_prescaler, tim_period, tim_pulse, tim_counter;
  logic [1:0]  tim_mode;

  always #5 clk = ~clk;

  tim_ctrl #(.CNT_W(16), .BUS_W(32)) dut (
    .clk(clk), .rst(rst),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .tim_rst(tim_rst), .tim_prescaler(tim_prescaler), .tim_mode(tim_mode),
    .tim_period(tim_period), .tim_pulse(tim_pulse), .tim_counter(tim_counter),
    .irq(irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase 0=stopped, 1=loading, 2=running; index 1/2/3 = PSC/ARR/CCR.
  localparam int P_STOP = 0, P_LOAD = 1, P_RUN = 2;
  int          m_phase;
  logic        m_en, m_opm, m_arpe, m_ack;
  logic [1:0]  m_mode, m_amode, m_sr, m_ier;
  logic [15:0] m_sh[1:3];
  logic [15:0] m_act[1:3];
  logic [15:0] m_prev;
  logic [31:0] m_rdata;
  logic [15:0] t_div;
  logic        t_up;

  task automatic model_reset();
    m_phase = P_STOP; m_en = 0; m_opm = 0; m_arpe = 0; m_ack = 0;
    m_mode = 0; m_amode = 0; m_sr = 0; m_ier = 0; m_prev = 0; m_rdata = 0;
    for (int i = 1; i <= 3; i++) begin
      m_sh[i] = 0;
      m_act[i] = 0;
    end
  endtask

  // One clock cycle: drive inputs, predict, clock, then compare at the falling edge.
  task automatic step(input logic r, input logic s, input logic w,
                      input logic [2:0] a, input logic [31:0] d);
    logic [15:0] n_sh[1:3];
    logic [15:0] n_act[1:3];
    logic        n_en, n_opm, n_arpe, ug, moved, uev, cce, copy, t_u;
    logic [1:0]  n_mode, n_amode, n_sr, n_ier;
    logic [31:0] n_rdata;
    logic [15:0] n_prev, t_cnt, t_d, arr;
    int          n_phase;
    rst = r; bus_sel = s; bus_we = w; bus_addr = a; bus_wdata = d;

    // tim core reaction to what the controller presents before this edge
    t_cnt = tim_counter; t_d = t_div; t_u = t_up; arr = m_act[2];
    if (m_phase != P_RUN) begin
      t_cnt = 0; t_d = 0; t_u = 1;
    end else if (t_div < m_act[1]) begin
      t_d = t_div + 16'd1;
    end else begin
      t_d = 0;
      case (m_amode)
        2'd1: t_cnt = (tim_counter == 0 || tim_counter > arr) ? arr : tim_counter - 16'd1;
        2'd2: begin
          if (arr == 0) t_cnt = 0;
          else if (t_up) begin
            if (tim_counter >= arr) begin t_u = 0; t_cnt = tim_counter - 16'd1; end
            else t_cnt = tim_counter + 16'd1;
          end else begin
            if (tim_counter == 0) begin t_u = 1; t_cnt = 16'd1; end
            else t_cnt = tim_counter - 16'd1;
          end
        end
        default: t_cnt = (tim_counter >= arr) ? 16'd0 : tim_counter + 16'd1;
      endcase
    end

    n_sh = m_sh; n_act = m_act; n_en = m_en; n_opm = m_opm; n_arpe = m_arpe;
    n_mode = m_mode; n_amode = m_amode; n_sr = m_sr; n_ier = m_ier; n_phase = m_phase;
    n_rdata = 0;
    if (s && !w) begin
      case (a)
        3'd0: n_rdata = {27'd0, m_mode, m_arpe, m_opm, m_en};
        3'd1, 3'd2, 3'd3: n_rdata = {16'd0, m_sh[a]};
        3'd4: n_rdata = {16'd0, tim_counter};
        3'd5: n_rdata = {30'd0, m_sr};
        3'd6: n_rdata = {30'd0, m_ier};
        default: n_rdata = 0;
      endcase
    end
    moved = (m_phase == P_RUN) && (m_prev != tim_counter);
    uev   = moved && (tim_counter == ((m_amode == 2'd1) ? m_act[2] : 16'd0));
    cce   = moved && (tim_counter == m_act[3]);
    ug = 0;
    if (s && w) begin
      case (a)
        3'd0: begin n_en = d[0]; n_opm = d[1]; n_arpe = d[2]; n_mode = d[4:3]; ug = d[5]; end
        3'd1: n_sh[1] = d[15:0];
        3'd2, 3'd3: begin
          n_sh[a] = d[15:0];
          if (!m_arpe) n_act[a] = d[15:0];
        end
        3'd5: n_sr = m_sr & ~d[1:0];
        3'd6: n_ier = d[1:0];
        default: ;
      endcase
    end
    if (uev) begin
      n_sr[0] = 1;
      if (m_opm) n_en = 0;
    end
    if (cce) n_sr[1] = 1;
    n_prev = tim_counter;
    copy = uev;
    case (m_phase)
      P_STOP: begin
        if (ug) copy = 1;
        if (m_en) n_phase = P_LOAD;
      end
      P_LOAD: begin copy = 1; n_phase = P_RUN; n_prev = 0; end
      default: begin
        if (!n_en) n_phase = P_STOP;
        else if (ug) n_phase = P_LOAD;
      end
    endcase
    if (copy) begin
      n_act = n_sh;
      n_amode = n_mode;
    end

    @(posedge clk);
    #1;
    tim_counter = t_cnt; t_div = t_d; t_up = t_u;
    if (r) model_reset();
    else begin
      m_sh = n_sh; m_act = n_act; m_en = n_en; m_opm = n_opm; m_arpe = n_arpe;
      m_mode = n_mode; m_amode = n_amode; m_sr = n_sr; m_ier = n_ier;
      m_phase = n_phase; m_prev = n_prev; m_ack = s; m_rdata = n_rdata;
    end
    @(negedge clk);
    check("ack", 32'(bus_ack), 32'(m_ack));
    check("rdata", bus_rdata, m_rdata);
    check("tim_rst", 32'(tim_rst), 32'(m_phase != P_RUN));
    check("psc", 32'(tim_prescaler), 32'(m_act[1]));
    check("period", 32'(tim_period), 32'(m_act[2]));
    check("pulse", 32'(tim_pulse), 32'(m_act[3]));
    check("mode", 32'(tim_mode), 32'(m_amode));
    check("irq", 32'(irq), 32'(|(m_sr & m_ier)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 3'd0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(0, 1, 1, a, d);
    $display("WR addr=%0d data=%h", a, d);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    step(0, 1, 0, a, 32'd0);
    v = bus_rdata;
    $display("RD addr=%0d data=%h", a, v);
  endtask

  task automatic wait_cnt(input logic [15:0] c);
    for (int i = 0; i < 200 && tim_counter != c; i++) idle(1);
    check("wait_cnt", 32'(tim_counter), 32'(c));
  endtask

  initial begin
    logic [31:0] v, d, f;
    logic [2:0]  a;
    rst = 1; bus_sel = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
    tim_counter = 0; t_div = 0; t_up = 1;
    model_reset();

    // reset
    step(1, 0, 0, 3'd0, 32'd0);
    step(1, 0, 0, 3'd0, 32'd0);
    check("rst_tim_rst", 32'(tim_rst), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(bus_ack), 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check("rst_read", v, 32'd0);
    end

    // up count with both interrupts enabled
    wr(3'd1, 32'd0); wr(3'd2, 32'd4); wr(3'd3, 32'd2); wr(3'd6, 32'd3); wr(3'd0, 32'd1);
    idle(20);
    rd(3'd5, v);
    check("up_sr", v, 32'd3);
    check("up_irq", 32'(irq), 32'd1);
    wait_cnt(16'd1);
    wr(3'd5, 32'd1);
    rd(3'd5, v);
    check("w1c_uif_only", v, 32'd2);

    // ARR preload
    wr(3'd0, 32'd0); wr(3'd2, 32'd9); wr(3'd0, 32'd5);
    wait_cnt(16'd5);
    wr(3'd2, 32'd3);
    check("pre_hold", 32'(tim_period), 32'd9);
    wait_cnt(16'd0);
    check("pre_before_wrap", 32'(tim_period), 32'd9);
    idle(1);
    check("pre_after_wrap", 32'(tim_period), 32'd3);
    wr(3'd0, 32'd1);
    wr(3'd2, 32'd6);
    check("direct_arr", 32'(tim_period), 32'd6);

    // one-pulse, down mode
    wr(3'd0, 32'd0); wr(3'd5, 32'd3); wr(3'd2, 32'd3); wr(3'd0, 32'h0B);
    idle(8);
    rd(3'd0, v);
    check("opm_ctrl", v, 32'h0A);
    check("opm_tim_rst", 32'(tim_rst), 32'd1);
    check("opm_cnt", 32'(tim_counter), 32'd0);
    rd(3'd5, v);
    check("opm_sr", v, 32'd1);

    // W1C collides with update event
    wr(3'd2, 32'd4); wr(3'd0, 32'd1);
    wait_cnt(16'd4); wait_cnt(16'd0);
    wr(3'd5, 32'd1);
    rd(3'd5, v);
    check("w1c_collide", 32'(v[0]), 32'd1);
    // EN cleared on the update cycle
    wait_cnt(16'd2);
    wr(3'd5, 32'd3);
    wait_cnt(16'd0);
    wr(3'd0, 32'd0);
    check("en_uev_stop", 32'(tim_rst), 32'd1);
    rd(3'd5, v);
    check("en_uev_uif", 32'(v[0]), 32'd1);

    // UG restart mid-count
    wr(3'd2, 32'd9); wr(3'd5, 32'd3); wr(3'd0, 32'd1);
    wait_cnt(16'd7);
    wr(3'd0, 32'h21);
    check("ug_load", 32'(tim_rst), 32'd1);
    rd(3'd5, v);
    check("ug_uif", 32'(v[0]), 32'd0);
    check("ug_cnt", 32'(tim_counter), 32'd0);
    idle(6);

    // reset mid-run
    step(1, 0, 0, 3'd0, 32'd0);
    check("mid_rst_tim_rst", 32'(tim_rst), 32'd1);
    check("mid_rst_period", 32'(tim_period), 32'd0);
    check("mid_rst_irq", 32'(irq), 32'd0);
    idle(2);

    // randomized bus traffic against the model
    for (int i = 0; i < 3000; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      case (a)
        3'd0: f = {26'd0, 1'($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 7) != 0)};
        3'd1: f = 32'($urandom_range(0, 2));
        3'd2, 3'd3: f = 32'($urandom_range(0, 9));
        default: f = 32'($urandom_range(0, 3));
      endcase
      d = {d[31:16], f[15:0]};
      step(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), a, d);
    end
    $display("random phase done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tim_ctrl.md
Name: tim_ctrl

Overview:
Register-mapped controller that configures and sequences one tim core (prescaler, up/down/up-down counter, PWM compare) from the CPU peripheral bus.
- Holds shadow/active copies of PSC, ARR and CCR.
- Starts and stops the timer by holding its reset.
- Detects update (reload) and compare events from the sampled counter.
- Supports one-pulse mode and raises a maskable interrupt.
- Sits between the bus decoder and the tim instance.

Parameters:
- CNT_W, 16, width of timer counter, PSC, ARR and CCR.
- BUS_W, 32, bus data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- bus_sel  in  1  access request; each cycle with bus_sel=1 is one access.
- bus_we  in  1  1=write, 0=read.
- bus_addr  in  3  word register index.
- bus_wdata  in  BUS_W  write data.
- bus_rdata  out  BUS_W  read data; valid while bus_ack=1.
- bus_ack  out  1  one cycle after bus_sel sampled.
- tim_rst  out  1  drives tim rst; high holds counter at 0.
- tim_prescaler  out  CNT_W  active PSC.
- tim_mode  out  2  counter_mode (00 up, 01 down, 10 up-down).
- tim_period  out  CNT_W  active ARR.
- tim_pulse  out  CNT_W  active CCR.
- tim_counter  in  CNT_W  tim out_counter.
- irq  out  1  |(SR & IER).

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst.
- Reset values:
  - bus_ack=0, bus_rdata=0.
  - tim_rst=1, all active/shadow registers 0, tim_mode=00.
  - SR=0, IER=0, CTRL=0, irq=0.
  - FSM in STOP.
- Register map (word index):
  - 0 CTRL: [0] EN, [1] OPM, [2] ARPE, [4:3] MODE, [5] UG (write-only, self-clearing, reads 0).
  - 1 PSC shadow.
  - 2 ARR shadow.
  - 3 CCR shadow.
  - 4 CNT: read-only, returns tim_counter.
  - 5 SR: [0] UIF, [1] CCIF; write 1 to clear.
  - 6 IER: [0] UIE, [1] CCIE.
  - 7: reads 0, writes ignored.
- Bus access:
  - Write takes effect at the edge where bus_sel=1 is sampled.
  - bus_ack and bus_rdata are registered, so they appear the next cycle.
  - Unused bits read 0.
- Preload:
  - PSC is always preloaded.
  - ARR and CCR write the active copy directly when ARPE=0, and the shadow copy only when ARPE=1.
  - Every shadow→active transfer copies PSC, ARR, CCR and MODE.
- Event detection:
  - cnt_q holds tim_counter from the previous cycle; moved = (cnt_q != tim_counter); events are evaluated only in RUN.
  - Update event (uev) = moved and:
    - up: tim_counter==0
    - down: tim_counter==active ARR
    - up-down: tim_counter==0
  - Compare event = moved and tim_counter==active CCR.
  - ARR=0 in up or up-down mode: the counter never moves, so no events. Documented limitation.
- FSM:
  - STOP: tim_rst=1. EN=1 → LOAD.
  - LOAD (exactly 1 cycle): tim_rst=1, shadow→active, cnt_q←0 → RUN.
  - RUN: tim_rst=0.
    - EN=0 → STOP.
    - UG write → LOAD (restart). UG does not set UIF.
    - On uev: UIF←1, shadow→active.
    - On uev with OPM=1: EN←0 and → STOP.
- Priorities and simultaneous events:
  - Hardware set beats a same-cycle W1C: the flag stays 1.
  - A CTRL write clearing EN in the same cycle as uev: go to STOP, UIF still set, shadow transfer still occurs.
  - UG with EN=0 performs shadow→active only and stays in STOP.
  - A write to the MODE field while in RUN takes effect only at the next transfer.
  - Reset during RUN returns everything to reset values the next cycle and forces tim_rst=1.
- Sizing: CNT_W wide compares only; no arithmetic beyond equality.

Test Plan:
- Reset: assert rst 2 cycles → tim_rst=1, irq=0, all registers read 0, bus_ack=0.
- Up count:
  - Stimulus: PSC=0, ARR=4, CCR=2, IER=3, CTRL=EN.
  - Response: tim_counter cycles 0..4.
  - Response: UIF sets in the cycle tim_counter 4→0 is observed.
  - Response: CCIF sets at the 1→2 transition; irq=1.
  - Response: writing SR=1 clears only UIF.
- Preload:
  - Stimulus: ARPE=1, running with ARR=9; write ARR=3 while counter=5.
  - Response: tim_period stays 9 until the next wrap 9→0, then becomes 3.
  - Contrast: with ARPE=0, tim_period becomes 3 one cycle after the write.
- One-pulse:
  - Stimulus: OPM=1, down mode, ARR=3.
  - Response: after reload 0→3, EN reads 0, FSM goes to STOP, tim_rst=1, tim_counter held at 0, UIF=1.
- Collisions:
  - W1C of UIF in the same cycle as uev → UIF stays 1.
  - EN=0 written on the uev cycle → STOP with UIF=1.
- UG and reset:
  - Write UG at counter=7 → one-cycle LOAD, counter restarts from 0, UIF unchanged.
  - rst mid-run → all outputs return to reset values.
